counter_interact_ctrl: RTL and testbench

// Sequences pick-up / put-down interactions between the penguin and the kitchen counters.
// On an interact key press while the penguin touches a counter, performs a read-modify-write
// of that tile's item in the single-port counter item RAM and updates the penguin's held item.

---
 rtl/counter_interact_ctrl.sv | 130 +++++++++++++
 tb/tb_counter_interact_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_interact_ctrl.sv
// Kitchen counter pick-up / put-down sequencer with a shared item RAM port.
// The penguin owns the port during an interaction; the aux requester gets idle cycles.
module counter_interact_ctrl #(
    parameter logic [7:0] INTERACT_KEY = 8'h2C,
    parameter int         ITEM_W       = 3,
    parameter int         TILE_W       = 7,
    parameter int         TRASH_TILE   = 95
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    input  logic              wallFlag,
    input  logic [TILE_W-1:0] tileIndex,
    output logic [TILE_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [ITEM_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [ITEM_W-1:0] mem_wdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [TILE_W-1:0] aux_addr,
    input  logic [ITEM_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic [ITEM_W-1:0] heldSpriteIndex,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CHK,
        WR,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic                key_prev;
    logic                key_now;
    logic                rise;
    logic [TILE_W-1:0]   addr_q, addr_nxt;
    logic [ITEM_W-1:0]   held_nxt;
    logic [ITEM_W-1:0]   wdata_q, wdata_nxt;
    logic                put_q, put_nxt;
    logic                is_trash;

    assign key_now  = (keycode == INTERACT_KEY);
    assign rise     = key_now & ~key_prev;
    assign is_trash = (addr_q == TILE_W'(TRASH_TILE));
    assign busy     = (state != IDLE);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            key_prev        <= 1'b0;
            addr_q          <= '0;
            heldSpriteIndex <= '0;
            wdata_q         <= '0;
            put_q           <= 1'b0;
        end else begin
            state           <= state_nxt;
            key_prev        <= key_now;
            addr_q          <= addr_nxt;
            heldSpriteIndex <= held_nxt;
            wdata_q         <= wdata_nxt;
            put_q           <= put_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        held_nxt  = heldSpriteIndex;
        wdata_nxt = wdata_q;
        put_nxt   = put_q;
        mem_addr  = addr_q;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = wdata_q;
        aux_gnt   = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise && wallFlag) begin
                    addr_nxt  = tileIndex;
                    state_nxt = RD;
                end else if (aux_req && !Reset) begin
                    aux_gnt   = 1'b1;
                    mem_addr  = aux_addr;
                    mem_rd_en = ~aux_we;
                    mem_wr_en = aux_we;
                    mem_wdata = aux_wdata;
                end
            end
            RD: begin
                mem_rd_en = 1'b1;
                state_nxt = CHK;
            end
            CHK: begin
                // Trash swallows the held item without touching the RAM.
                if (is_trash) begin
                    held_nxt  = '0;
                    state_nxt = DONE;
                end else if (heldSpriteIndex == '0 && mem_rdata != '0) begin
                    held_nxt  = mem_rdata;
                    wdata_nxt = '0;
                    put_nxt   = 1'b0;
                    state_nxt = WR;
                end else if (heldSpriteIndex != '0 && mem_rdata == '0) begin
                    wdata_nxt = heldSpriteIndex;
                    put_nxt   = 1'b1;
                    state_nxt = WR;
                end else begin
                    state_nxt = DONE;
                end
            end
            WR: begin
                mem_wr_en = 1'b1;
                if (put_q) held_nxt = '0;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_counter_interact_ctrl.sv
// Directed bench for counter_interact_ctrl with a behavioural item RAM.
module tb_counter_interact_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       wallFlag;
    logic [6:0] tileIndex;
    logic [6:0] mem_addr;
    logic       mem_rd_en;
    logic [2:0] mem_rdata;
    logic       mem_wr_en;
    logic [2:0] mem_wdata;
    logic       aux_req;
    logic       aux_we;
    logic [6:0] aux_addr;
    logic [2:0] aux_wdata;
    logic       aux_gnt;
    logic [2:0] heldSpriteIndex;
    logic       busy;
    logic       done;

    counter_interact_ctrl dut (
        .frame_clk       (frame_clk),
        .Reset           (Reset),
        .keycode         (keycode),
        .wallFlag        (wallFlag),
        .tileIndex       (tileIndex),
        .mem_addr        (mem_addr),
        .mem_rd_en       (mem_rd_en),
        .mem_rdata       (mem_rdata),
        .mem_wr_en       (mem_wr_en),
        .mem_wdata       (mem_wdata),
        .aux_req         (aux_req),
        .aux_we          (aux_we),
        .aux_addr        (aux_addr),
        .aux_wdata       (aux_wdata),
        .aux_gnt         (aux_gnt),
        .heldSpriteIndex (heldSpriteIndex),
        .busy            (busy),
        .done            (done)
    );

    always #5 frame_clk = ~frame_clk;

    logic [2:0] ram [128] = '{default: '0};
    logic [2:0] rdata_q = '0;

    always @(posedge frame_clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) rdata_q <= ram[mem_addr];
    end
    assign mem_rdata = rdata_q;

    int cyc = 0;
    int done_cnt = 0, done_cyc = -1;
    int wr_cnt = 0, rd_cnt = 0, busy_cnt = 0;
    int gnt_cnt = 0, gnt_cyc = -1;
    logic [6:0] wr_addr = '0, rd_addr = '0;
    logic [2:0] wr_data = '0;

    // Event log sampled mid-cycle, indexed by cycle number.
    always @(negedge frame_clk) begin
        cyc <= cyc + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (mem_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (mem_rd_en) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= mem_addr;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (aux_gnt) begin
            gnt_cnt <= gnt_cnt + 1;
            gnt_cyc <= cyc;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic aux_write(input logic [6:0] a, input logic [2:0] d);
        int g0, k;
        g0 = gnt_cnt;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = a; aux_wdata = d;
        k = 0;
        while (gnt_cnt == g0 && k < 20) begin step(1); k++; end
        aux_req = 1'b0; aux_we = 1'b0;
        step(1);
        check("aux_wr", {29'd0, ram[a]}, {29'd0, d});
    endtask

    task automatic press(input logic [6:0] tile, input int hold,
                         output int lat);
        int e, d0, k;
        tileIndex = tile; wallFlag = 1'b1; keycode = 8'h2C;
        e = cyc; d0 = done_cnt; k = 0;
        while (done_cnt == d0 && k < 20) begin step(1); k++; end
        lat = (done_cnt == d0) ? -1 : done_cyc - e;
        if (hold > 0) step(hold);
        keycode = 8'h00;
        step(2);
    endtask

    int lat, d0, w0, r0, b0, g0, e, k;

    initial begin
        Reset = 1'b1; keycode = 8'h00; wallFlag = 1'b0; tileIndex = '0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
        step(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_held", heldSpriteIndex, 0);
        check("rst_strobes", {mem_rd_en, mem_wr_en, aux_gnt}, 0);
        check("rst_addr", mem_addr, 0);
        Reset = 1'b0;
        step(2);

        aux_write(7'd12, 3'd3);
        aux_write(7'd30, 3'd2);
        aux_write(7'd60, 3'd4);
        aux_write(7'd70, 3'd6);

        // Pick up item 3 from tile 12.
        press(7'd12, 0, lat);
        check("pick_lat", lat, 4);
        check("pick_held", heldSpriteIndex, 3);
        check("pick_rd_addr", rd_addr, 12);
        check("pick_wr_addr", wr_addr, 12);
        check("pick_wr_data", wr_data, 0);
        check("pick_ram", ram[12], 0);

        // Put down on empty tile 20 while holding the key.
        d0 = done_cnt;
        press(7'd20, 8, lat);
        check("put_lat", lat, 4);
        check("put_held", heldSpriteIndex, 0);
        check("put_wr", {wr_addr, 1'b0, wr_data}, {7'd20, 1'b0, 3'd3});
        check("put_ram", ram[20], 3);
        check("hold_one_done", done_cnt - d0, 1);

        press(7'd30, 0, lat);
        check("held2", heldSpriteIndex, 2);
        aux_write(7'd20, 3'd5);

        // Both full: no-op.
        w0 = wr_cnt;
        press(7'd20, 0, lat);
        check("noop_lat", lat, 3);
        check("noop_held", heldSpriteIndex, 2);
        check("noop_no_wr", wr_cnt - w0, 0);
        check("noop_ram", ram[20], 5);

        b0 = busy_cnt; r0 = rd_cnt;
        tileIndex = 7'd20; wallFlag = 1'b0; keycode = 8'h2C;
        step(5);
        keycode = 8'h00;
        step(2);
        check("nowall_busy", busy_cnt - b0, 0);
        check("nowall_rd", rd_cnt - r0, 0);

        press(7'd50, 0, lat);
        check("put50_ram", ram[50], 2);
        press(7'd60, 0, lat);
        check("held4", heldSpriteIndex, 4);

        // Trash discards without writing.
        w0 = wr_cnt;
        press(7'd95, 0, lat);
        check("trash_lat", lat, 3);
        check("trash_held", heldSpriteIndex, 0);
        check("trash_no_wr", wr_cnt - w0, 0);

        // Aux write collides with a key edge; penguin goes first.
        g0 = gnt_cnt; r0 = rd_cnt;
        tileIndex = 7'd12; wallFlag = 1'b1; keycode = 8'h2C;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 7'd7; aux_wdata = 3'd1;
        e = cyc; k = 0;
        while (gnt_cnt == g0 && k < 20) begin step(1); k++; end
        aux_req = 1'b0; aux_we = 1'b0; keycode = 8'h00;
        step(2);
        check("arb_done_cyc", done_cyc - e, 3);
        check("arb_gnt_cyc", gnt_cyc - e, 4);
        check("arb_gnt_once", gnt_cnt - g0, 1);
        check("arb_rd_once", rd_cnt - r0, 1);
        check("arb_ram7", ram[7], 1);

        // Reset during the CHK cycle of a pick-up.
        w0 = wr_cnt; d0 = done_cnt;
        tileIndex = 7'd70; wallFlag = 1'b1; keycode = 8'h2C;
        step(2);
        check("abort_in_chk", {busy, mem_rd_en, mem_wr_en}, 3'b100);
        Reset = 1'b1;
        #1;
        check("abort_busy_now", busy, 0);
        step(2);
        Reset = 1'b0; keycode = 8'h00;
        step(3);
        check("abort_no_wr", wr_cnt - w0, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_held", heldSpriteIndex, 0);
        check("abort_busy", busy, 0);
        check("abort_ram", ram[70], 6);
        aux_write(7'd71, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
